// File: rtl/ksa_rr_scheduler.sv
// Round-robin front end for one shared pipelined Kogge-Stone adder.
// Tags ride alongside the adder; results land in a credit-protected FIFO.
module ksa_rr_scheduler #(
    parameter int N     = 4,
    parameter int BITS  = 64,
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    localparam int IDW  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*BITS-1:0] req_a,
    input  logic [N*BITS-1:0] req_b,
    input  logic [N-1:0]      req_c,
    output logic [BITS-1:0]   add_a,
    output logic [BITS-1:0]   add_b,
    output logic              add_c,
    input  logic [BITS:0]     add_s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [BITS:0]     rsp_s,
    output logic              busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } tag_t;

    tag_t           tag_q [LAT];
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] g;
    logic           found;
    logic           credit_ok;
    logic           issue;
    logic [CW-1:0]  inflight;
    logic [CW:0]    used;
    logic [CW-1:0]  count_q;
    logic [PW-1:0]  rd_q;
    logic [PW-1:0]  wr_q;
    logic           push;
    logic           pop;
    logic [BITS:0]  s_mem  [DEPTH];
    logic [IDW-1:0] id_mem [DEPTH];
    int             j;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < LAT; k++) begin
            if (tag_q[k].v) inflight = inflight + CW'(1);
        end
    end

    // Queued results plus in-flight tags must fit, so the adder never stalls.
    assign used      = {1'b0, count_q} + {1'b0, inflight};
    assign credit_ok = rst_n && (used < (CW+1)'(DEPTH));

    always_comb begin
        found = 1'b0;
        g     = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_q) + i) % N;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                g     = IDW'(j);
            end
        end
    end

    assign issue     = credit_ok & found;
    assign req_ready = issue ? (N'(1) << g) : '0;
    assign ptr_nxt   = (int'(g) == N - 1) ? '0 : g + IDW'(1);

    assign add_a = issue ? req_a[int'(g)*BITS +: BITS] : '0;
    assign add_b = issue ? req_b[int'(g)*BITS +: BITS] : '0;
    assign add_c = issue ? req_c[g] : 1'b0;

    assign push = tag_q[LAT-1].v;
    assign pop  = (count_q != '0) & rsp_ready;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
        end else begin
            if (issue) ptr_q <= ptr_nxt;
            tag_q[0] <= '{v: issue, id: g};
            for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
            if (push) wr_q <= wrap_inc(wr_q);
            if (pop)  rd_q <= wrap_inc(rd_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; count masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            s_mem[wr_q]  <= add_s;
            id_mem[wr_q] <= tag_q[LAT-1].id;
        end
    end

    assign rsp_valid = (count_q != '0);
    assign rsp_s     = s_mem[rd_q];
    assign rsp_id    = id_mem[rd_q];
    assign busy      = (inflight != '0) | (count_q != '0);

endmodule

// File: tb/tb_ksa_rr_scheduler.sv
// Scoreboard bench for ksa_rr_scheduler with a behavioural 2-stage adder.
// Accepted requests feed a queue; a negedge monitor checks each response.
module tb_ksa_rr_scheduler;

    localparam int N     = 4;
    localparam int BITS  = 64;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*BITS-1:0] req_a;
    logic [N*BITS-1:0] req_b;
    logic [N-1:0]      req_c;
    logic [BITS-1:0]   add_a;
    logic [BITS-1:0]   add_b;
    logic              add_c;
    logic [BITS:0]     add_s;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [BITS:0]     rsp_s;
    logic              busy;

    logic [BITS-1:0] a_r [N];
    logic [BITS-1:0] b_r [N];
    logic            c_r [N];
    logic [BITS:0]   e_r [N];

    typedef struct {
        logic [IDW-1:0] id;
        logic [BITS:0]  s;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_a[i*BITS +: BITS] = a_r[i];
        assign req_b[i*BITS +: BITS] = b_r[i];
        assign req_c[i]              = c_r[i];
    end

    logic [BITS:0] s1, s2;
    always @(posedge clk) begin
        s1 <= {1'b0, add_a} + {1'b0, add_b} + {{BITS{1'b0}}, add_c};
        s2 <= s1;
    end
    assign add_s = s2;

    ksa_rr_scheduler #(
        .N(N), .BITS(BITS), .LAT(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_s(add_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_s(rsp_s), .busy(busy)
    );

    task automatic chk(input string name, input logic [BITS:0] act,
                       input logic [BITS:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i])
                sb.push_back('{id: IDW'(i), s: e_r[i]});
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d s %h expected none",
                         rsp_id, rsp_s);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", {{(BITS+1-IDW){1'b0}}, rsp_id},
                    {{(BITS+1-IDW){1'b0}}, e.id});
                chk("rsp_s", rsp_s, e.s);
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic setop(input int i, input logic [BITS-1:0] a,
                         input logic [BITS-1:0] b, input logic c,
                         input logic [BITS:0] e);
        a_r[i] = a;
        b_r[i] = b;
        c_r[i] = c;
        e_r[i] = e;
    endtask

    task automatic do_reset;
        cyc();
        rst_n = 1'b0;
        sb.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic drain;
        int n;
        n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (busy && n < 40) begin
            cyc();
            n++;
        end
        cyc();
        chk("drain_busy", {64'd0, busy}, 65'd0);
        chk("sb_empty", 65'(sb.size()), 65'd0);
    endtask

    initial begin
        int hs;
        int maxc;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) setop(i, '0, '0, 1'b0, '0);

        // reset state, with requests already asserted
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        req_valid = 4'b1111;
        smp();
        chk("reset_req_ready", 65'(req_ready), 65'd0);
        chk("reset_rsp_valid", 65'(rsp_valid), 65'd0);
        chk("reset_busy", 65'(busy), 65'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        req_valid = '0;

        // single op from requester 1
        rsp_ready = 1'b1;
        cyc();
        setop(1, 64'd5, 64'd7, 1'b1, 65'd13);
        req_valid = 4'b0010;
        smp();
        chk("single_grant", 65'(req_ready), 65'b0010);
        cyc();
        req_valid = '0;
        smp();
        chk("single_t1_valid", 65'(rsp_valid), 65'd0);
        chk("single_t1_busy", 65'(busy), 65'd1);
        cyc();
        smp();
        chk("single_t2_valid", 65'(rsp_valid), 65'd0);
        cyc();
        smp();
        chk("single_t3_valid", 65'(rsp_valid), 65'd1);
        cyc();
        smp();
        chk("single_busy_clear", 65'(busy), 65'd0);

        // round robin from reset
        do_reset();
        for (int i = 0; i < N; i++)
            setop(i, BITS'(i*16 + 1), 64'd2, 1'b0, 65'(i*16 + 3));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("rr_grant", 65'(req_ready), 65'(1 << (k % 4)));
            cyc();
        end
        drain();

        // carry-out
        req_valid = 4'b1000;
        setop(3, '1, 64'd1, 1'b0, 65'h1_0000_0000_0000_0000);
        smp();
        chk("carry_grant0", 65'(req_ready), 65'b1000);
        cyc();
        setop(3, '1, '1, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF);
        smp();
        chk("carry_grant1", 65'(req_ready), 65'b1000);
        cyc();
        drain();

        // backpressure
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        hs = 0;
        for (int k = 0; k < 10; k++) begin
            setop(0, BITS'(100 + k), BITS'(k), 1'b0, 65'(100 + 2*k));
            smp();
            if (req_ready[0]) hs++;
            cyc();
        end
        smp();
        chk("bp_handshakes", 65'(hs), 65'd4);
        chk("bp_req_ready", 65'(req_ready), 65'd0);
        chk("bp_count", 65'(dut.count_q), 65'd4);
        chk("bp_rsp_valid", 65'(rsp_valid), 65'd1);
        cyc();
        rsp_ready = 1'b1;
        for (int k = 10; k < 18; k++) begin
            setop(0, BITS'(100 + k), BITS'(k), 1'b0, 65'(100 + 2*k));
            smp();
            cyc();
        end
        drain();

        // toggling consumer under full load
        do_reset();
        req_valid = 4'b1111;
        maxc = 0;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++)
                setop(i, BITS'(k*8 + i), BITS'(1000*i), k[0],
                      65'(k*8 + i + 1000*i + (k & 1)));
            rsp_ready = k[0];
            smp();
            if (int'(dut.count_q) > maxc) maxc = int'(dut.count_q);
            cyc();
        end
        chk("toggle_count_bound", 65'(maxc <= DEPTH), 65'd1);
        drain();

        // reset with 2 in flight and 2 queued
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            setop(2, BITS'(50 + k), 64'd1, 1'b0, 65'(51 + k));
            smp();
            chk("mid_grant", 65'(req_ready), 65'b0100);
            cyc();
        end
        chk("mid_count", 65'(dut.count_q), 65'd2);
        rst_n = 1'b0;
        req_valid = 4'b1111;
        sb.delete();
        smp();
        chk("mid_rsp_valid", 65'(rsp_valid), 65'd0);
        chk("mid_busy", 65'(busy), 65'd0);
        chk("mid_req_ready", 65'(req_ready), 65'd0);
        cyc();
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        setop(0, 64'd9, 64'd9, 1'b0, 65'd18);
        smp();
        chk("mid_ptr_restart", 65'(req_ready), 65'b0001);
        cyc();
        req_valid = '0;
        for (int k = 0; k < 6; k++) cyc();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
